// File: rtl/imem_cache_if.sv
// rtl/imem_cache_if.sv - fetch-side and backing-memory signal bundle for imem_cache
//
// Purpose: groups the fetch port, the invalidate pulse, the refill read bus
// and the miss counter into a single bundle.
// Modports:
//   slave  - the cache itself: takes the fetch address, invalidate, ack and read data;
//            drives instruction data, stall, the refill request/address and the miss count.
//   master - the environment (fetch stage plus backing memory): the mirror image of slave.
// Signals:
//   imem_addr_i  [31:0] fetch PC; bits [1:0] are ignored
//   imem_data_o  [31:0] instruction word; NOP when not a hit
//   imem_stall_o        high when imem_data_o is not valid this cycle
//   invalidate_i        one-cycle pulse that clears every valid bit
//   mem_req_o           backing-memory read request
//   mem_addr_o   [31:0] word-aligned backing-memory read address
//   mem_ack_i           backing memory returns mem_rdata_i this cycle
//   mem_rdata_i  [31:0] backing-memory read data
//   miss_count_o [31:0] saturating count of refills started

interface imem_cache_if;
  logic [31:0] imem_addr_i;
  logic [31:0] imem_data_o;
  logic        imem_stall_o;
  logic        invalidate_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic [31:0] miss_count_o;

  modport slave (
    input  imem_addr_i, invalidate_i, mem_ack_i, mem_rdata_i,
    output imem_data_o, imem_stall_o, mem_req_o, mem_addr_o, miss_count_o
  );

  modport master (
    output imem_addr_i, invalidate_i, mem_ack_i, mem_rdata_i,
    input  imem_data_o, imem_stall_o, mem_req_o, mem_addr_o, miss_count_o
  );
endinterface

// File: rtl/imem_cache.sv
// rtl/imem_cache.sv - direct-mapped instruction cache with in-order line refill
//
// Purpose: serves instruction fetches combinationally on a hit; on a miss it
// stalls fetch and refills the whole line from backing memory, word 0 first.
// Ports:
//   clk   - single clock, all state updates on the rising edge
//   rst_n - asynchronous active-low reset
//   bus   - imem_cache_if.slave: fetch address/data/stall, invalidate pulse,
//           refill request/address/ack/data and the saturating miss counter
// Parameters:
//   NUM_LINES      - number of direct-mapped lines (power of 2)
//   WORDS_PER_LINE - 32-bit words per line (power of 2, at least 2)

module imem_cache #(
  parameter int NUM_LINES      = 8,
  parameter int WORDS_PER_LINE = 4
) (
  input logic         clk,
  input logic         rst_n,
  imem_cache_if.slave bus
);

  localparam int OFF_W = $clog2(WORDS_PER_LINE);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = 30 - OFF_W - IDX_W;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic {IDLE, REFILL} state_t;

  state_t               state_q;
  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [31:0]          data_q [NUM_LINES][WORDS_PER_LINE];

  logic [TAG_W-1:0]     lat_tag_q;
  logic [IDX_W-1:0]     lat_idx_q;
  logic [OFF_W-1:0]     cnt_q;
  logic                 inv_seen_q;
  logic                 mem_req_q;
  logic [31:0]          mem_addr_q;
  logic [31:0]          miss_q;

  logic [OFF_W-1:0]     off;
  logic [IDX_W-1:0]     idx;
  logic [TAG_W-1:0]     tag;
  logic [OFF_W-1:0]     cnt_nxt;
  logic                 hit;
  logic                 last_word;
  logic                 refill_ack;

  assign off        = bus.imem_addr_i[OFF_W+1:2];
  assign idx        = bus.imem_addr_i[OFF_W+IDX_W+1:OFF_W+2];
  assign tag        = bus.imem_addr_i[31:OFF_W+IDX_W+2];
  assign cnt_nxt    = cnt_q + 1'b1;
  assign last_word  = (cnt_q == OFF_W'(WORDS_PER_LINE - 1));
  assign refill_ack = (state_q == REFILL) && bus.mem_ack_i;

  // Tag memory is not reset; the valid bit gates any stale/unknown tag.
  assign hit = (state_q == IDLE) && valid_q[idx] && (tag_q[idx] == tag);

  assign bus.imem_data_o  = hit ? data_q[idx][off] : NOP;
  assign bus.imem_stall_o = !hit;
  assign bus.mem_req_o    = mem_req_q;
  assign bus.mem_addr_o   = mem_addr_q;
  assign bus.miss_count_o = miss_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      lat_tag_q  <= '0;
      lat_idx_q  <= '0;
      cnt_q      <= '0;
      inv_seen_q <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      miss_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.invalidate_i) valid_q <= '0;
          if (!hit) begin
            lat_tag_q  <= tag;
            lat_idx_q  <= idx;
            cnt_q      <= '0;
            inv_seen_q <= 1'b0;
            mem_req_q  <= 1'b1;
            mem_addr_q <= {tag, idx, {OFF_W{1'b0}}, 2'b00};
            if (miss_q != 32'hFFFF_FFFF) miss_q <= miss_q + 32'd1;
            state_q    <= REFILL;
          end
        end
        REFILL: begin
          // An invalidate seen at any point of the refill poisons the line
          // being fetched, so the data from before the fence is never served.
          if (bus.invalidate_i) begin
            valid_q    <= '0;
            inv_seen_q <= 1'b1;
          end
          if (bus.mem_ack_i) begin
            if (last_word) begin
              mem_req_q <= 1'b0;
              state_q   <= IDLE;
              if (!bus.invalidate_i && !inv_seen_q) valid_q[lat_idx_q] <= 1'b1;
            end else begin
              cnt_q      <= cnt_nxt;
              mem_addr_q <= {lat_tag_q, lat_idx_q, cnt_nxt, 2'b00};
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Line storage has no reset; it is only written by acknowledged refill beats.
  always_ff @(posedge clk) begin
    if (refill_ack) begin
      data_q[lat_idx_q][cnt_q] <= bus.mem_rdata_i;
      if (last_word) tag_q[lat_idx_q] <= lat_tag_q;
    end
  end

endmodule

// File: tb/tb_imem_cache.sv
// tb/tb_imem_cache.sv - self-checking bench for imem_cache

module tb_imem_cache;
  logic clk;
  logic rst_n;
  imem_cache_if bus();

  imem_cache #(.NUM_LINES(8), .WORDS_PER_LINE(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [31:0] NOP = 32'h0000_0013;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        stall;
  } vec_t;

  vec_t vecs[8];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents address a (expected to miss) and plays backing memory: word k of
  // the line returns base+k after 'waits' idle cycles. Checks every request
  // address/hold, the stall length, refill word count, miss counter and the
  // word returned once the line is in.
  task automatic fetch_miss(input logic [31:0] a, input logic [31:0] base,
                            input int waits, input bit inv_last,
                            input int exp_stalls, input logic [31:0] exp_miss);
    int  k      = 0;
    int  w      = 0;
    int  stalls = 0;
    int  guard  = 0;
    bit  seen   = 0;
    bit  acked;
    logic [31:0] line_base;
    line_base = {a[31:4], 4'b0000};
    bus.imem_addr_i = a;
    #1;
    while (bus.imem_stall_o && k < 4 && guard < 60) begin
      stalls++;
      guard++;
      acked = 0;
      if (bus.mem_req_o) begin
        seen = 1;
        chk("mem_addr", bus.mem_addr_o, line_base + 32'(k * 4));
        if (w < waits) begin
          w++;
        end else begin
          bus.mem_ack_i   = 1'b1;
          bus.mem_rdata_i = base + 32'(k);
          acked = 1;
          if (inv_last && k == 3) bus.invalidate_i = 1'b1;
        end
      end else if (seen) begin
        chk("req_held", {31'b0, bus.mem_req_o}, 32'd1);
      end
      @(posedge clk);
      #1;
      bus.mem_ack_i    = 1'b0;
      bus.invalidate_i = 1'b0;
      bus.mem_rdata_i  = 32'h0;
      if (acked) begin
        k++;
        w = 0;
      end
      #1;
    end
    chk("refill_words", 32'(k), 32'd4);
    chk("stall_cycles", 32'(stalls), 32'(exp_stalls));
    chk("miss_count", bus.miss_count_o, exp_miss);
    chk("req_dropped", {31'b0, bus.mem_req_o}, 32'd0);
    if (inv_last) begin
      chk("inv_stall", {31'b0, bus.imem_stall_o}, 32'd1);
      chk("inv_data", bus.imem_data_o, NOP);
    end else begin
      chk("post_stall", {31'b0, bus.imem_stall_o}, 32'd0);
      chk("post_data", bus.imem_data_o, base + 32'(a[3:2]));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{32'h0000_0000, 32'h0000_00A0, 1'b0};
    vecs[1] = '{32'h0000_0004, 32'h0000_00A1, 1'b0};
    vecs[2] = '{32'h0000_0008, 32'h0000_00A2, 1'b0};
    vecs[3] = '{32'h0000_000C, 32'h0000_00A3, 1'b0};
    vecs[4] = '{32'h0000_0010, 32'h0000_00B0, 1'b0};
    vecs[5] = '{32'h0000_0014, 32'h0000_00B1, 1'b0};
    vecs[6] = '{32'h0000_0018, 32'h0000_00B2, 1'b0};
    vecs[7] = '{32'h0000_001C, 32'h0000_00B3, 1'b0};

    rst_n            = 1'b0;
    bus.imem_addr_i  = 32'h0;
    bus.invalidate_i = 1'b0;
    bus.mem_ack_i    = 1'b0;
    bus.mem_rdata_i  = 32'h0;
    step();
    step();
    chk("rst_req", {31'b0, bus.mem_req_o}, 32'd0);
    chk("rst_addr", bus.mem_addr_o, 32'h0);
    chk("rst_miss", bus.miss_count_o, 32'h0);
    chk("rst_stall", {31'b0, bus.imem_stall_o}, 32'd1);
    chk("rst_data", bus.imem_data_o, NOP);
    rst_n = 1'b1;
    #1;

    // Cold miss, then a conflicting tag on index 0, then back to the first line.
    fetch_miss(32'h0000_0000, 32'h0000_00A0, 0, 0, 5, 32'd1);
    fetch_miss(32'h0000_0080, 32'h0000_00C0, 0, 0, 5, 32'd2);
    fetch_miss(32'h0000_0000, 32'h0000_00A0, 0, 0, 5, 32'd3);
    // Slow memory: three wait cycles in front of every beat.
    fetch_miss(32'h0000_0010, 32'h0000_00B0, 3, 0, 17, 32'd4);

    for (int i = 0; i < 8; i++) begin
      bus.imem_addr_i = vecs[i].addr;
      #1;
      chk("vec_data", bus.imem_data_o, vecs[i].data);
      chk("vec_stall", {31'b0, bus.imem_stall_o}, {31'b0, vecs[i].stall});
      chk("vec_req", {31'b0, bus.mem_req_o}, 32'd0);
      step();
    end

    // Stray ack while idle must not touch the cache.
    bus.imem_addr_i = 32'h0000_0004;
    bus.mem_ack_i   = 1'b1;
    bus.mem_rdata_i = 32'hDEAD_BEEF;
    step();
    bus.mem_ack_i   = 1'b0;
    bus.mem_rdata_i = 32'h0;
    #1;
    chk("stray_data", bus.imem_data_o, 32'h0000_00A1);
    chk("stray_miss", bus.miss_count_o, 32'd4);
    chk("stray_req", {31'b0, bus.mem_req_o}, 32'd0);

    // Invalidate on the last ack: line stays invalid, refetch counts a miss.
    fetch_miss(32'h0000_0020, 32'h0000_00D0, 0, 1, 5, 32'd5);
    fetch_miss(32'h0000_0020, 32'h0000_00E0, 0, 0, 5, 32'd6);
    fetch_miss(32'h0000_0004, 32'h0000_00A0, 0, 0, 5, 32'd7);

    // Invalidate while idle: the hit in that cycle still returns stored data.
    bus.imem_addr_i  = 32'h0000_0004;
    bus.invalidate_i = 1'b1;
    #1;
    chk("inv_idle_data", bus.imem_data_o, 32'h0000_00A1);
    chk("inv_idle_stall", {31'b0, bus.imem_stall_o}, 32'd0);
    step();
    bus.invalidate_i = 1'b0;
    #1;
    chk("inv_after_stall", {31'b0, bus.imem_stall_o}, 32'd1);
    chk("inv_after_data", bus.imem_data_o, NOP);
    fetch_miss(32'h0000_0004, 32'h0000_0060, 0, 0, 5, 32'd8);

    // Reset in the middle of a refill after two beats.
    bus.imem_addr_i = 32'h0000_0030;
    step();
    chk("mid_req", {31'b0, bus.mem_req_o}, 32'd1);
    chk("mid_addr0", bus.mem_addr_o, 32'h0000_0030);
    bus.mem_ack_i   = 1'b1;
    bus.mem_rdata_i = 32'h0000_00F0;
    step();
    chk("mid_addr1", bus.mem_addr_o, 32'h0000_0034);
    bus.mem_rdata_i = 32'h0000_00F1;
    step();
    bus.mem_ack_i   = 1'b0;
    bus.mem_rdata_i = 32'h0;
    #1;
    chk("mid_addr2", bus.mem_addr_o, 32'h0000_0038);
    rst_n = 1'b0;
    #1;
    chk("abort_req", {31'b0, bus.mem_req_o}, 32'd0);
    chk("abort_miss", bus.miss_count_o, 32'h0);
    step();
    rst_n = 1'b1;
    #1;
    chk("post_rst_stall", {31'b0, bus.imem_stall_o}, 32'd1);
    fetch_miss(32'h0000_0030, 32'h0000_0050, 0, 0, 5, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_cache.md
IMEM_CACHE -- requirements
Module: imem_cache

Interface
REQ-001 Parameter: NUM_LINES, 8, number of direct-mapped lines (power of 2).
REQ-002 Parameter: WORDS_PER_LINE, 4, 32-bit words per line (power of 2).
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 Port: imem_addr_i  input  32  fetch PC from the fetch stage; bits [1:0] ignored.
REQ-006 Port: imem_data_o  output  32  instruction at imem_addr_i; combinational on hit.
REQ-007 Port: imem_stall_o  output  1  high when imem_data_o is not valid this cycle; drives the fetch stall.
REQ-008 Port: invalidate_i  input  1  one-cycle pulse (fence.i); clears all valid bits.
REQ-009 Port: mem_req_o  output  1  backing-memory read request.
REQ-010 Port: mem_addr_o  output  32  word-aligned backing-memory read address.
REQ-011 Port: mem_ack_i  input  1  backing memory returns mem_rdata_i this cycle.
REQ-012 Port: mem_rdata_i  input  32  backing-memory read data.
REQ-013 Port: miss_count_o  output  32  saturating count of refills started.

Function
REQ-014 Address split: offset = addr[log2(WPL)+1:2], index = next log2(NUM_LINES) bits, tag = remaining upper bits (defaults: [3:2], [6:4], [31:7]).
REQ-015 Storage per line: valid bit, tag, WORDS_PER_LINE data words.
REQ-016 hit = state IDLE and valid[index] and tag match, combinational from imem_addr_i.
REQ-017 On hit: imem_data_o = stored word, imem_stall_o = 0, zero added latency.
REQ-018 When not hit: imem_data_o = 32'h00000013 (NOP), imem_stall_o = 1.
REQ-019 FSM states: IDLE, REFILL.
REQ-020 IDLE with miss: latch tag/index of imem_addr_i, clear word counter, go to REFILL next cycle, increment miss_count_o.
REQ-021 REFILL: mem_req_o = 1, mem_addr_o = {latched tag, latched index, counter, 2'b00}; words fetched in order 0..WPL-1, not critical-word-first.
REQ-022 mem_req_o and mem_addr_o held stable until mem_ack_i; a request is never withdrawn once raised.
REQ-023 Each mem_ack_i in REFILL writes mem_rdata_i into word[counter] of the latched line; counter increments.
REQ-024 On ack of the last word: set valid and tag of the latched line, return to IDLE; the following cycle re-evaluates imem_addr_i (hit if unchanged).
REQ-025 Minimum miss penalty: 1 detect cycle + WPL ack cycles; imem_stall_o stays 1 throughout REFILL.
REQ-026 imem_addr_i changes during REFILL (redirect) do not abort the refill; the line completes, then IDLE re-evaluates the new address.
REQ-027 mem_ack_i outside REFILL is ignored.
REQ-028 invalidate_i in IDLE: all valid bits 0 next cycle; hits that cycle still return stored data.
REQ-029 invalidate_i during REFILL: all valid bits cleared; the line being refilled completes its bus transfers but is NOT marked valid (invalidate wins over the last-word validate in the same cycle).
REQ-030 miss_count_o saturates at 32'hFFFFFFFF.

Reset
REQ-031 Reset asynchronously clears all valid bits, state = IDLE, counter = 0, mem_req_o = 0, mem_addr_o = 0, miss_count_o = 0; data/tag arrays need no reset.
REQ-032 Reset asserted during REFILL aborts immediately: mem_req_o = 0, no line validated.
REQ-033 After deassertion the first fetch of any address misses.

Verification
REQ-034 Cold miss: reset, addr 0x00000000, ack every cycle with 0xA0,0xA1,0xA2,0xA3 -> mem_addr_o 0x0,0x4,0x8,0xC; stall 5 cycles; then data 0xA0, stall 0, miss_count_o = 1.
REQ-035 Same-line hits: after REQ-034, addr 0x4,0x8,0xC -> data 0xA1,0xA2,0xA3, stall 0, mem_req_o 0.
REQ-036 Conflict: addr 0x80 (same index 0, tag 1) -> refill from 0x80; then addr 0x0 misses again; miss_count_o = 3.
REQ-037 Slow memory: ack after 3 wait cycles per word -> mem_req_o/mem_addr_o stable across waits; correct words stored.
REQ-038 Invalidate on last ack of a refill -> line not valid; same address refetches, miss_count_o increments.
REQ-039 Reset mid-REFILL after 2 acks -> mem_req_o 0 at once; post-reset fetch of that address misses and refills all 4 words.
